// File: rtl/nd_1to2_pkg.sv
// nd_1to2_pkg: shared widths, output handshake states and message sizing for the split node
package nd_1to2_pkg;
  localparam int NS_1TO2_FSZ = 2;
  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE = 8;
  localparam int NS_REDUN_SIZE = 4;
  localparam bit ON = 1'b1;
  localparam bit OFF = 1'b0;
  typedef enum logic [1:0] {OS_IDLE, OS_REQ, OS_DRAIN} out_state_t;
  function automatic int msg_width(input int asz, input int dsz, input int rsz);
    return 2 * asz + dsz + rsz;
  endfunction
endpackage

// File: rtl/nd_msg_fifo.sv
// nd_msg_fifo: synchronous FIFO of packed {src,dst,dat,red} messages, 2^FSZ entries
module nd_msg_fifo #(
  parameter int FSZ = 2,
  parameter int W = 28
) (
  input  logic         i_clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**FSZ];
  logic [FSZ:0] wp, rp;
  logic do_push, do_pop;
  assign full = (wp[FSZ] != rp[FSZ]) && (wp[FSZ-1:0] == rp[FSZ-1:0]);
  assign empty = wp == rp;
  assign rdata = mem[rp[FSZ-1:0]];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // pointers wrap modulo 2^(FSZ+1); clr discards everything held
  always_ff @(posedge i_clk)
    if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  // message storage, no reset needed since empty masks stale entries
  always_ff @(posedge i_clk)
    if (do_push && !clr) mem[wp[FSZ-1:0]] <= wdata;
endmodule

// File: rtl/nd_1to2.sv
// nd_1to2: split node routing one 4-phase input channel onto two buffered output channels
module nd_1to2 import nd_1to2_pkg::*; #(
  parameter int FSZ = NS_1TO2_FSZ,
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE,
  parameter int RBIT = 0
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  input  logic [ASZ-1:0] rcv0_src,
  input  logic [ASZ-1:0] rcv0_dst,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  output logic           snd0_req,
  input  logic           snd0_ack,
  output logic [ASZ-1:0] snd0_src,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,
  output logic           snd1_req,
  input  logic           snd1_ack,
  output logic [ASZ-1:0] snd1_src,
  output logic [ASZ-1:0] snd1_dst,
  output logic [DSZ-1:0] snd1_dat,
  output logic [RSZ-1:0] snd1_red
);
  localparam int W = msg_width(ASZ, DSZ, RSZ);
  logic [1:0] push, pop, full, empty, req, ack;
  logic [W-1:0] rdata [2];
  logic [W-1:0] out_msg [2];
  logic [W-1:0] wdata;
  logic clr, sel, accept;
  assign clr = reset || !ready;
  assign sel = rcv0_dst[RBIT];
  assign accept = ready && rcv0_req && !rcv0_ack && !full[sel];
  assign push = {accept && sel, accept && !sel};
  assign wdata = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
  assign ack = {snd1_ack, snd0_ack};
  assign snd0_req = req[0];
  assign snd1_req = req[1];
  assign {snd0_src, snd0_dst, snd0_dat, snd0_red} = out_msg[0];
  assign {snd1_src, snd1_dst, snd1_dat, snd1_red} = out_msg[1];
  // one init edge after reset, then the input side acks once per accepted message
  always_ff @(posedge i_clk)
    if (reset) begin
      ready <= 1'b0;
      rcv0_ack <= 1'b0;
    end else if (!ready) begin
      ready <= 1'b1;
      rcv0_ack <= 1'b0;
    end else if (accept) rcv0_ack <= 1'b1;
    else if (!rcv0_req) rcv0_ack <= 1'b0;
  for (genvar k = 0; k < 2; k++) begin : g_out
    out_state_t st;
    logic req_r;
    logic [W-1:0] msg_r;
    assign pop[k] = ready && st == OS_IDLE && !empty[k];
    assign req[k] = req_r;
    assign out_msg[k] = msg_r;
    nd_msg_fifo #(.FSZ(FSZ), .W(W)) u_fifo (
      .i_clk(i_clk),
      .clr(clr),
      .push(push[k]),
      .pop(pop[k]),
      .wdata(wdata),
      .rdata(rdata[k]),
      .full(full[k]),
      .empty(empty[k])
    );
    // output handshake: load head into the register, hold req until ack, then wait for ack to fall
    always_ff @(posedge i_clk)
      if (clr) begin
        st <= OS_IDLE;
        req_r <= 1'b0;
        msg_r <= '0;
      end else
        case (st)
          OS_IDLE:
            if (pop[k]) begin
              st <= OS_REQ;
              req_r <= 1'b1;
              msg_r <= rdata[k];
            end
          OS_REQ:
            if (ack[k]) begin
              st <= OS_DRAIN;
              req_r <= 1'b0;
            end
          OS_DRAIN: if (!ack[k]) st <= OS_IDLE;
          default: st <= OS_IDLE;
        endcase
  end
endmodule

// File: tb/tb_nd_1to2.sv
// tb_nd_1to2: directed self-checking bench for the split node
module tb_nd_1to2;
  import nd_1to2_pkg::*;
  localparam int ASZ = NS_ADDRESS_SIZE;
  localparam int DSZ = NS_DATA_SIZE;
  localparam int RSZ = NS_REDUN_SIZE;
  localparam int W = msg_width(ASZ, DSZ, RSZ);
  logic i_clk = 1'b0;
  logic reset = 1'b1;
  logic ready, rcv0_ack, snd0_req, snd1_req;
  logic rcv0_req = 1'b0;
  logic [ASZ-1:0] rcv0_src = '0, rcv0_dst = '0;
  logic [DSZ-1:0] rcv0_dat = '0;
  logic [RSZ-1:0] rcv0_red = '0;
  logic [ASZ-1:0] snd0_src, snd0_dst, snd1_src, snd1_dst;
  logic [DSZ-1:0] snd0_dat, snd1_dat;
  logic [RSZ-1:0] snd0_red, snd1_red;
  logic [1:0] ack_v = 2'b00;
  logic [1:0] en = 2'b11;
  logic [1:0] rnd = 2'b00;
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  int dlv [2] = '{0, 0};
  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  nd_1to2 dut (
    .i_clk(i_clk), .reset(reset), .ready(ready),
    .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
    .rcv0_src(rcv0_src), .rcv0_dst(rcv0_dst), .rcv0_dat(rcv0_dat), .rcv0_red(rcv0_red),
    .snd0_req(snd0_req), .snd0_ack(ack_v[0]),
    .snd0_src(snd0_src), .snd0_dst(snd0_dst), .snd0_dat(snd0_dat), .snd0_red(snd0_red),
    .snd1_req(snd1_req), .snd1_ack(ack_v[1]),
    .snd1_src(snd1_src), .snd1_dst(snd1_dst), .snd1_dat(snd1_dat), .snd1_red(snd1_red)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int i, input logic [ASZ-1:0] d);
    return {ASZ'(i + 16), d, DSZ'(32'hA0 ^ i), RSZ'(i)};
  endfunction

  task automatic present(input logic [W-1:0] m);
    {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = m;
    rcv0_req = 1'b1;
  endtask

  task automatic wait_ack(input string tag, input logic v, input int lim);
    for (int n = 0; n < lim && rcv0_ack !== v; n++) @(negedge i_clk);
    chk(tag, rcv0_ack, v);
  endtask

  task automatic send(input logic [W-1:0] m, input int k);
    if (k == 0) q0.push_back(m);
    else q1.push_back(m);
    present(m);
    wait_ack("acc", 1'b1, 12);
    rcv0_req = 1'b0;
    wait_ack("rel", 1'b0, 4);
  endtask

  task automatic wait_drain(input string tag, input int lim);
    for (int n = 0; n < lim && (q0.size() != 0 || q1.size() != 0 || snd0_req || snd1_req || ack_v != 2'b00); n++)
      @(negedge i_clk);
    chk(tag, q0.size() + q1.size(), 0);
  endtask

  // responder for both outputs: checks each new message against the expected queue, acks after a delay
  initial begin
    int cnt [2];
    logic [1:0] seen;
    logic r;
    logic [W-1:0] got, exp;
    cnt = '{0, 0};
    seen = 2'b00;
    forever begin
      @(negedge i_clk);
      for (int k = 0; k < 2; k++) begin
        r = (k == 0) ? snd0_req : snd1_req;
        got = (k == 0) ? {snd0_src, snd0_dst, snd0_dat, snd0_red} : {snd1_src, snd1_dst, snd1_dat, snd1_red};
        if (reset) begin
          ack_v[k] = 1'b0;
          seen[k] = 1'b0;
        end else if (ack_v[k]) begin
          if (!r) begin
            ack_v[k] = 1'b0;
            seen[k] = 1'b0;
          end
        end else if (r && en[k]) begin
          if (!seen[k]) begin
            seen[k] = 1'b1;
            cnt[k] = rnd[k] ? int'($urandom_range(3, 0)) : 0;
            if ((k == 0 ? q0.size() : q1.size()) == 0) chk(k == 0 ? "unexp_req0" : "unexp_req1", r, 1'b0);
            else begin
              exp = (k == 0) ? q0.pop_front() : q1.pop_front();
              chk(k == 0 ? "msg0" : "msg1", got, exp);
              dlv[k]++;
            end
          end
          if (cnt[k] == 0) ack_v[k] = 1'b1;
          else cnt[k]--;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] m1, m2, m;
    int base;
    repeat (3) begin
      @(negedge i_clk);
      chk("rst_ready", ready, 1'b0);
      chk("rst_hs", {rcv0_ack, snd1_req, snd0_req}, 3'b000);
    end
    chk("rst_fields", {snd0_src, snd0_dst, snd0_dat, snd0_red, snd1_src, snd1_dst, snd1_dat, snd1_red}, 0);
    @(posedge i_clk);
    #1 reset = 1'b0;
    @(negedge i_clk);
    chk("ready_e1", ready, 1'b0);
    @(negedge i_clk);
    chk("ready_e2", ready, 1'b1);
    chk("init_hs", {rcv0_ack, snd1_req, snd0_req}, 3'b000);

    m1 = {8'h33, 8'h04, 8'hA5, 4'h9};
    m2 = {8'h33, 8'h05, 8'hA5, 4'h9};
    q0.push_back(m1);
    present(m1);
    @(negedge i_clk);
    chk("acc_lat", rcv0_ack, 1'b1);
    chk("req_lat_n1", snd0_req, 1'b0);
    rcv0_req = 1'b0;
    @(negedge i_clk);
    chk("req_lat_n2", snd0_req, 1'b1);
    chk("route0_fld", {snd0_src, snd0_dst, snd0_dat, snd0_red}, m1);
    chk("route0_no1", snd1_req, 1'b0);
    send(m2, 1);
    wait_drain("route_drain", 40);
    chk("route1_fld", {snd1_src, snd1_dst, snd1_dat, snd1_red}, m2);
    chk("route_dlv", {dlv[0][7:0], dlv[1][7:0]}, 16'h0101);

    en[0] = 1'b0;
    for (int i = 0; i < 5; i++) send(mk(i, 8'h02), 0);
    m = mk(5, 8'h02);
    q0.push_back(m);
    present(m);
    repeat (8) @(negedge i_clk);
    chk("bp_stall", rcv0_ack, 1'b0);
    chk("bp_req", snd0_req, 1'b1);
    chk("bp_head", {snd0_src, snd0_dst, snd0_dat, snd0_red}, mk(0, 8'h02));
    base = dlv[0];
    en[0] = 1'b1;
    for (int n = 0; n < 10 && dlv[0] == base; n++) @(negedge i_clk);
    en[0] = 1'b0;
    chk("bp_one_hs", dlv[0], base + 1);
    wait_ack("bp_acc", 1'b1, 10);
    rcv0_req = 1'b0;
    wait_ack("bp_rel", 1'b0, 4);

    m = mk(6, 8'h02);
    q0.push_back(m);
    present(m);
    repeat (6) @(negedge i_clk);
    chk("ind_stall", rcv0_ack, 1'b0);
    chk("ind_snd1_idle", snd1_req, 1'b0);
    en[0] = 1'b1;
    wait_ack("ind_acc", 1'b1, 40);
    rcv0_req = 1'b0;
    wait_ack("ind_rel", 1'b0, 4);
    send(mk(7, 8'h03), 1);
    wait_drain("ind_drain", 80);
    chk("ind_dlv", {dlv[0][7:0], dlv[1][7:0]}, 16'h0802);

    rnd[1] = 1'b1;
    for (int i = 0; i < 20; i++) send(mk(20 + i, 8'h81), 1);
    wait_drain("wrap_drain", 200);
    chk("wrap_dlv", dlv[1], 22);

    en[0] = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(50 + i, 8'h10), 0);
    chk("mr_req", snd0_req, 1'b1);
    @(posedge i_clk);
    #1 reset = 1'b1;
    q0.delete();
    @(negedge i_clk);
    @(negedge i_clk);
    chk("mr_hs", {rcv0_ack, snd1_req, snd0_req}, 3'b000);
    chk("mr_ready", ready, 1'b0);
    chk("mr_fld", {snd0_src, snd0_dst, snd0_dat, snd0_red}, 0);
    @(posedge i_clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("mr_reinit", ready, 1'b1);
    en[0] = 1'b1;
    repeat (15) @(negedge i_clk);
    chk("mr_stale", snd0_req, 1'b0);
    send(mk(60, 8'h08), 0);
    wait_drain("mr_drain", 40);
    chk("mr_dlv", dlv[0], 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
